// File: rtl/sync_edges_multi_if.sv
// sync_edges_multi_if
//   Groups the per-channel inputs and outputs of sync_edges_multi.
//   master : drives testmode_i, asyn_i, clr_pos_i, clr_neg_i, irq_mask_i;
//            observes syn_o, syn_del_o, posedge_o, negedge_o,
//            pos_flag_o, neg_flag_o, irq_o
//   slave  : the synchroniser itself (mirror image of master)
//   There is no handshake: every signal is a plain level sampled or
//   produced on each rising clock edge.
interface sync_edges_multi_if #(
  parameter int WIDTH = 4
);
  logic             testmode_i;
  logic [WIDTH-1:0] asyn_i;
  logic [WIDTH-1:0] clr_pos_i;
  logic [WIDTH-1:0] clr_neg_i;
  logic [WIDTH-1:0] irq_mask_i;
  logic [WIDTH-1:0] syn_o;
  logic [WIDTH-1:0] syn_del_o;
  logic [WIDTH-1:0] posedge_o;
  logic [WIDTH-1:0] negedge_o;
  logic [WIDTH-1:0] pos_flag_o;
  logic [WIDTH-1:0] neg_flag_o;
  logic             irq_o;

  modport master (
    output testmode_i, asyn_i, clr_pos_i, clr_neg_i, irq_mask_i,
    input  syn_o, syn_del_o, posedge_o, negedge_o, pos_flag_o, neg_flag_o, irq_o
  );

  modport slave (
    input  testmode_i, asyn_i, clr_pos_i, clr_neg_i, irq_mask_i,
    output syn_o, syn_del_o, posedge_o, negedge_o, pos_flag_o, neg_flag_o, irq_o
  );
endinterface

// File: rtl/sync_edges_multi.sv
// sync_edges_multi
//   Multi-channel synchroniser with edge detection for GPIO / button /
//   sensor inputs. Each channel: STAGES-deep sync chain, optional debounce
//   filter, one-cycle delayed level, one-cycle pos/neg edge pulses and
//   sticky write-one-clear edge flags, OR-reduced into a maskable irq.
//
//   Optional feature macro: SYNC_EDGES_FILTER_EN
//     defined   -> per-channel debounce filter after the sync chain; a new
//                  level is accepted after FILTER_CYC consecutive cycles
//                  that differ from the current level.
//     undefined -> level is the last sync flop; FILTER_CYC is unused.
//
// Ports
//   clk_i    : clock, all state on rising edge
//   reset_i  : synchronous active-high reset
//   bus      : sync_edges_multi_if.slave
//     testmode_i : bypass, syn/syn_del/posedge/negedge all show asyn_i
//     asyn_i     : asynchronous inputs
//     clr_pos_i  : W1C for pos_flag_o (a same-cycle edge wins)
//     clr_neg_i  : W1C for neg_flag_o (a same-cycle edge wins)
//     irq_mask_i : per-channel irq enable
//     syn_o      : synchronised (filtered) level
//     syn_del_o  : syn_o delayed by one cycle
//     posedge_o  : one-cycle pulse on 0->1 of the level
//     negedge_o  : one-cycle pulse on 1->0 of the level
//     pos_flag_o : sticky rising-edge flags
//     neg_flag_o : sticky falling-edge flags
//     irq_o      : |((pos_flag_o | neg_flag_o) & irq_mask_i)
module sync_edges_multi #(
  parameter int               WIDTH      = 4,
  parameter int               STAGES     = 2,
  parameter int               FILTER_CYC = 4,
  parameter logic [WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic           clk_i,
  input  logic           reset_i,
  sync_edges_multi_if.slave bus
);

  // Elaboration-time parameter sanity checks.
  if (WIDTH < 1) begin : g_chk_width
    $error("sync_edges_multi: WIDTH must be >= 1");
  end
  if (STAGES < 2) begin : g_chk_stages
    $error("sync_edges_multi: STAGES must be >= 2");
  end
  if (FILTER_CYC < 1) begin : g_chk_filter
    $error("sync_edges_multi: FILTER_CYC must be >= 1");
  end

  // Sync chain: sync_q[0] captures the async input, sync_q[STAGES-1]
  // is the value considered safe to use in this clock domain.
  logic [STAGES-1:0][WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int k = 0; k < STAGES; k++) begin
        sync_q[k] <= RESET_VAL;
      end
    end else begin
      sync_q[0] <= bus.asyn_i;
      for (int k = 1; k < STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  logic [WIDTH-1:0] synced;
  logic [WIDTH-1:0] lvl;

  assign synced = sync_q[STAGES-1];

`ifdef SYNC_EDGES_FILTER_EN
  // Debounce: count consecutive cycles where the synced value differs from
  // the accepted level; any agreeing cycle restarts the count. The counter
  // is reset on acceptance, so it never exceeds FILTER_CYC-1.
  localparam int                CNT_W   = $clog2(FILTER_CYC + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(FILTER_CYC - 1);

  logic [WIDTH-1:0][CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0]            lvl_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      lvl_q <= RESET_VAL;
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (synced[i] == lvl_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_MAX) begin
          lvl_q[i] <= synced[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign lvl = lvl_q;
`else
  assign lvl = synced;
`endif

  // Delayed level and edge detection (edges are combinational from flops).
  logic [WIDTH-1:0] del_q;
  logic [WIDTH-1:0] edge_pos;
  logic [WIDTH-1:0] edge_neg;
  logic [WIDTH-1:0] flag_set_en;
  logic [WIDTH-1:0] pos_flag_q;
  logic [WIDTH-1:0] neg_flag_q;

  assign edge_pos    = lvl & ~del_q;
  assign edge_neg    = ~lvl & del_q;
  // In test mode the internal edges are not allowed to set flags, so the
  // flag state only changes through the clear inputs.
  assign flag_set_en = {WIDTH{~bus.testmode_i}};

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      del_q      <= RESET_VAL;
      pos_flag_q <= '0;
      neg_flag_q <= '0;
    end else begin
      del_q      <= lvl;
      // Set has priority over a same-cycle clear.
      pos_flag_q <= (pos_flag_q & ~bus.clr_pos_i) | (edge_pos & flag_set_en);
      neg_flag_q <= (neg_flag_q & ~bus.clr_neg_i) | (edge_neg & flag_set_en);
    end
  end

  assign bus.syn_o      = bus.testmode_i ? bus.asyn_i : lvl;
  assign bus.syn_del_o  = bus.testmode_i ? bus.asyn_i : del_q;
  assign bus.posedge_o  = bus.testmode_i ? bus.asyn_i : edge_pos;
  assign bus.negedge_o  = bus.testmode_i ? bus.asyn_i : edge_neg;
  assign bus.pos_flag_o = pos_flag_q;
  assign bus.neg_flag_o = neg_flag_q;
  assign bus.irq_o      = |((pos_flag_q | neg_flag_q) & bus.irq_mask_i);

endmodule

// File: tb/tb_sync_edges_multi.sv
// tb_sync_edges_multi
//   Directed bench for sync_edges_multi (WIDTH=4, STAGES=2, FILTER_CYC=4,
//   RESET_VAL=0). Inputs change 1 ns after a rising edge and outputs are
//   checked at that same point, well away from the next active edge.
module tb_sync_edges_multi;
  localparam int WIDTH      = 4;
  localparam int STAGES     = 2;
  localparam int FILTER_CYC = 4;
`ifdef SYNC_EDGES_FILTER_EN
  localparam int LAT = STAGES + FILTER_CYC;
`else
  localparam int LAT = STAGES;
`endif

  logic clk = 1'b0;
  logic reset_i = 1'b1;
  int   checks = 0;
  int   failures = 0;

  sync_edges_multi_if #(.WIDTH(WIDTH)) bus ();

  sync_edges_multi #(
    .WIDTH(WIDTH), .STAGES(STAGES), .FILTER_CYC(FILTER_CYC), .RESET_VAL(4'h0)
  ) dut (
    .clk_i  (clk),
    .reset_i(reset_i),
    .bus    (bus)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_i        = 1'b1;
    bus.testmode_i = 1'b0;
    bus.asyn_i     = '0;
    bus.clr_pos_i  = '0;
    bus.clr_neg_i  = '0;
    tick();
    tick();
    reset_i = 1'b0;
  endtask

  // Scoreboard comparison
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.testmode_i = 1'b0;
    bus.asyn_i     = '0;
    bus.clr_pos_i  = '0;
    bus.clr_neg_i  = '0;
    bus.irq_mask_i = 4'hF;

    // ---- 1: reset held with inputs high, then release ----
    reset_i    = 1'b1;
    bus.asyn_i = 4'hF;
    repeat (3) tick();
    check("rst_syn", bus.syn_o, 4'h0);
    check("rst_del", bus.syn_del_o, 4'h0);
    check("rst_pflag", bus.pos_flag_o, 4'h0);
    check("rst_nflag", bus.neg_flag_o, 4'h0);
    check("rst_irq", bus.irq_o, 1'b0);
    reset_i = 1'b0;
    tick();
    check("rel_syn", bus.syn_o, 4'h0);
    check("rel_pos", bus.posedge_o, 4'h0);
    repeat (LAT - 2) tick();
    check("lat_syn_pre", bus.syn_o, 4'h0);
    tick();
    check("lat_syn", bus.syn_o, 4'hF);
    check("lat_pos", bus.posedge_o, 4'hF);
    check("lat_del", bus.syn_del_o, 4'h0);
    check("lat_pflag_pre", bus.pos_flag_o, 4'h0);
    tick();
    check("lat_pos_end", bus.posedge_o, 4'h0);
    check("lat_del_end", bus.syn_del_o, 4'hF);
    check("lat_pflag", bus.pos_flag_o, 4'hF);
    check("lat_nflag", bus.neg_flag_o, 4'h0);
    check("lat_irq", bus.irq_o, 1'b1);

`ifndef SYNC_EDGES_FILTER_EN
    // ---- 2: one-cycle pulse on channel 0 ----
    do_reset();
    bus.asyn_i = 4'h1;
    tick();
    bus.asyn_i = 4'h0;
    tick();
    check("p2_pos", bus.posedge_o, 4'h1);
    check("p2_neg0", bus.negedge_o, 4'h0);
    check("p2_syn", bus.syn_o, 4'h1);
    tick();
    check("p2_pos_end", bus.posedge_o, 4'h0);
    check("p2_neg", bus.negedge_o, 4'h1);
    check("p2_pflag", bus.pos_flag_o, 4'h1);
    tick();
    check("p2_neg_end", bus.negedge_o, 4'h0);
    check("p2_nflag", bus.neg_flag_o, 4'h1);
    bus.irq_mask_i = 4'h1;
    #1;
    check("p2_irq_en", bus.irq_o, 1'b1);
    bus.irq_mask_i = 4'hE;
    #1;
    check("p2_irq_mask", bus.irq_o, 1'b0);
    check("p2_mask_keep", bus.pos_flag_o, 4'h1);
    bus.irq_mask_i = 4'hF;
    bus.clr_pos_i  = 4'h1;
    bus.clr_neg_i  = 4'h1;
    tick();
    bus.clr_pos_i = 4'h0;
    bus.clr_neg_i = 4'h0;
    check("p2_clr_p", bus.pos_flag_o, 4'h0);
    check("p2_clr_n", bus.neg_flag_o, 4'h0);
    check("p2_clr_irq", bus.irq_o, 1'b0);
`else
    // ---- 3: filter drops a 3-cycle pulse, accepts a 4-cycle pulse ----
    do_reset();
    bus.asyn_i = 4'h2;
    repeat (3) tick();
    bus.asyn_i = 4'h0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("f3_drop_syn", bus.syn_o, 4'h0);
    end
    check("f3_drop_pflag", bus.pos_flag_o, 4'h0);
    check("f3_drop_nflag", bus.neg_flag_o, 4'h0);
    bus.asyn_i = 4'h2;
    repeat (4) tick();
    bus.asyn_i = 4'h0;
    tick();
    check("f3_acc_pre", bus.syn_o, 4'h0);
    tick();
    check("f3_acc_syn", bus.syn_o, 4'h2);
    check("f3_acc_pos", bus.posedge_o, 4'h2);
    tick();
    check("f3_acc_pflag", bus.pos_flag_o, 4'h2);
`endif

    // ---- 4: clear collides with edge, then clear alone ----
    do_reset();
    bus.asyn_i = 4'h4;
    repeat (LAT) tick();
    check("c4_pos", bus.posedge_o, 4'h4);
    bus.clr_pos_i = 4'h4;
    tick();
    check("c4_set_wins", bus.pos_flag_o, 4'h4);
    check("c4_irq_set", bus.irq_o, 1'b1);
    tick();
    bus.clr_pos_i = 4'h0;
    check("c4_cleared", bus.pos_flag_o, 4'h0);
    check("c4_irq_clr", bus.irq_o, 1'b0);

    // ---- 5: test mode bypass; flags frozen except for clears ----
    bus.asyn_i = 4'h0;
    repeat (LAT + 1) tick();
    check("t5_nflag_pre", bus.neg_flag_o, 4'h4);
    bus.testmode_i = 1'b1;
    bus.asyn_i     = 4'h5;
    #1;
    check("t5_syn", bus.syn_o, 4'h5);
    check("t5_del", bus.syn_del_o, 4'h5);
    check("t5_pos", bus.posedge_o, 4'h5);
    check("t5_neg", bus.negedge_o, 4'h5);
    repeat (LAT + 2) tick();
    check("t5_pflag_hold", bus.pos_flag_o, 4'h0);
    check("t5_nflag_hold", bus.neg_flag_o, 4'h4);
    check("t5_irq_hold", bus.irq_o, 1'b1);
    bus.clr_neg_i = 4'h4;
    tick();
    bus.clr_neg_i = 4'h0;
    check("t5_clr", bus.neg_flag_o, 4'h0);
    check("t5_irq_clr", bus.irq_o, 1'b0);
    bus.testmode_i = 1'b0;
    bus.asyn_i     = 4'h5;
    #1;
    check("t5_exit_syn", bus.syn_o, 4'h5);
    check("t5_exit_pos", bus.posedge_o, 4'h0);

    // ---- 6: reset mid-operation discards everything ----
    do_reset();
    bus.asyn_i = 4'hF;
    repeat (LAT + 1) tick();
    check("r6_pflag", bus.pos_flag_o, 4'hF);
    bus.asyn_i = 4'h0;
    repeat (STAGES + 2) tick();
    reset_i = 1'b1;
    tick();
    check("r6_pflag_rst", bus.pos_flag_o, 4'h0);
    check("r6_nflag_rst", bus.neg_flag_o, 4'h0);
    check("r6_syn_rst", bus.syn_o, 4'h0);
    check("r6_irq_rst", bus.irq_o, 1'b0);
    reset_i = 1'b0;
    for (int i = 0; i < LAT + 2; i++) begin
      tick();
      check("r6_no_pos", bus.posedge_o, 4'h0);
      check("r6_no_neg", bus.negedge_o, 4'h0);
    end
    check("r6_flags_quiet", {bus.pos_flag_o, bus.neg_flag_o}, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
